// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one single-port memory between two requesters
// One transaction in flight; mem_* driven from command registers, only mX_ready is combinational.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_mask,
  output logic                m0_ready,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_mask,
  output logic                m1_ready,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_prio_m1;
  logic                r_owner;
  logic [2:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_mask;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                w_gnt0;
  logic                w_gnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt0 || w_gnt1) w_next = S_ISSUE;
      S_ISSUE: w_next = r_we ? S_IDLE : S_WAIT;
      S_WAIT:  if (r_cnt == 3'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    mem_en    = 1'b0;
    if (r_state == S_IDLE && !reset) begin
      if (m0_req && m1_req) begin
        w_gnt1 = r_prio_m1;
        w_gnt0 = !r_prio_m1;
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
    end
    if (r_state == S_RESP) begin
      m0_rvalid = !r_owner;
      m1_rvalid = r_owner;
    end
    if (r_state == S_ISSUE) mem_en = 1'b1;
  end

  assign m0_ready  = w_gnt0;
  assign m1_ready  = w_gnt1;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_mask  = r_mask;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio_m1 <= 1'b0;
      r_owner   <= 1'b0;
      r_cnt     <= 3'd0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_we      <= w_gnt1 ? m1_we    : m0_we;
        r_addr    <= w_gnt1 ? m1_addr  : m0_addr;
        r_wdata   <= w_gnt1 ? m1_wdata : m0_wdata;
        r_mask    <= w_gnt1 ? m1_mask  : m0_mask;
        r_owner   <= w_gnt1;
        r_prio_m1 <= w_gnt0;
      end
      if (r_state == S_ISSUE && !r_we) r_cnt <= 3'(MEM_LATENCY);
      else if (r_state == S_WAIT)      r_cnt <= r_cnt - 3'd1;
      if (r_state == S_WAIT && r_cnt == 3'd1) begin
        if (r_owner) r_rdata1 <= mem_rdata;
        else         r_rdata0 <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
// Two instances: d1 with MEM_LATENCY=1 and d4 with MEM_LATENCY=4, each with a delay-line memory.
module tb_mem_bus_arbiter;

  logic        clk, reset;
  logic        m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_mask, m1_mask;
  logic        d1_m0_req, d1_m1_req, d4_m0_req, d4_m1_req;

  logic        d1_m0_ready, d1_m1_ready, d1_m0_rvalid, d1_m1_rvalid;
  logic [31:0] d1_m0_rdata, d1_m1_rdata;
  logic        d1_mem_en, d1_mem_we;
  logic [31:0] d1_mem_addr, d1_mem_wdata, d1_mem_rdata;
  logic [3:0]  d1_mem_mask;

  logic        d4_m0_ready, d4_m1_ready, d4_m0_rvalid, d4_m1_rvalid;
  logic [31:0] d4_m0_rdata, d4_m1_rdata;
  logic        d4_mem_en, d4_mem_we;
  logic [31:0] d4_mem_addr, d4_mem_wdata, d4_mem_rdata;
  logic [3:0]  d4_mem_mask;

  int n_chk = 0;
  int n_pass = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) d1 (
    .clk(clk), .reset(reset),
    .m0_req(d1_m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask),
    .m0_ready(d1_m0_ready), .m0_rvalid(d1_m0_rvalid), .m0_rdata(d1_m0_rdata),
    .m1_req(d1_m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask),
    .m1_ready(d1_m1_ready), .m1_rvalid(d1_m1_rvalid), .m1_rdata(d1_m1_rdata),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
    .mem_mask(d1_mem_mask), .mem_rdata(d1_mem_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) d4 (
    .clk(clk), .reset(reset),
    .m0_req(d4_m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask),
    .m0_ready(d4_m0_ready), .m0_rvalid(d4_m0_rvalid), .m0_rdata(d4_m0_rdata),
    .m1_req(d4_m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask),
    .m1_ready(d4_m1_ready), .m1_rvalid(d4_m1_rvalid), .m1_rdata(d4_m1_rdata),
    .mem_en(d4_mem_en), .mem_we(d4_mem_we), .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata),
    .mem_mask(d4_mem_mask), .mem_rdata(d4_mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h20) ? 32'h12345678 : (a ^ 32'hCAFE0000);
  endfunction

  // Memory models: read data is valid exactly MEM_LATENCY cycles after mem_en, garbage otherwise.
  logic        v1;
  logic [31:0] a1;
  logic [3:0]  v4;
  logic [31:0] a4 [4];
  always @(posedge clk) begin
    v1    <= d1_mem_en & ~d1_mem_we;
    a1    <= d1_mem_addr;
    v4    <= {v4[2:0], d4_mem_en & ~d4_mem_we};
    a4[0] <= d4_mem_addr;
    for (int i = 1; i < 4; i++) a4[i] <= a4[i-1];
  end
  assign d1_mem_rdata = v1    ? mem_val(a1)    : 32'hBAD0BAD0;
  assign d4_mem_rdata = v4[3] ? mem_val(a4[3]) : 32'hBAD0BAD0;

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    d1_m0_req = 1'b1;
    #1;
    n_chk++; if (d1_m0_ready !== 1'b0) $display("FAIL rst_ready: got %0b want 0", d1_m0_ready); else n_pass++;
    n_chk++; if ({d1_mem_en, d1_mem_we, d1_mem_addr, d1_mem_mask} !== 38'd0) $display("FAIL rst_mem: en=%0b addr=%h", d1_mem_en, d1_mem_addr); else n_pass++;
    n_chk++; if ({d1_m0_rvalid, d1_m1_rvalid, d1_m0_rdata, d1_m1_rdata} !== 66'd0) $display("FAIL rst_resp: rd0=%h rd1=%h", d1_m0_rdata, d1_m1_rdata); else n_pass++;
    @(negedge clk);
    d1_m0_req = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_write;
    @(negedge clk);
    m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_mask = 4'hF; d1_m0_req = 1'b1;
    #1;
    n_chk++; if ({d1_m0_ready, d1_m1_ready} !== 2'b10) $display("FAIL wr_ready: got %b want 10", {d1_m0_ready, d1_m1_ready}); else n_pass++;
    n_chk++; if (d1_mem_en !== 1'b0) $display("FAIL wr_en_T: got %0b want 0", d1_mem_en); else n_pass++;
    @(negedge clk);
    d1_m0_req = 1'b0;
    #1;
    n_chk++; if ({d1_mem_en, d1_mem_we} !== 2'b11) $display("FAIL wr_en_T1: got %b want 11", {d1_mem_en, d1_mem_we}); else n_pass++;
    n_chk++; if (d1_mem_addr !== 32'h10 || d1_mem_wdata !== 32'hDEADBEEF || d1_mem_mask !== 4'hF)
      $display("FAIL wr_fields: addr=%h wdata=%h mask=%h want 10 deadbeef f", d1_mem_addr, d1_mem_wdata, d1_mem_mask); else n_pass++;
    // Back-to-back: IDLE at T+2 proven by an immediate grant, here a zero-mask write from m1.
    @(negedge clk);
    m1_we = 1'b1; m1_addr = 32'h30; m1_wdata = 32'h55AA55AA; m1_mask = 4'h0; d1_m1_req = 1'b1;
    #1;
    n_chk++; if ({d1_mem_en, d1_m1_ready} !== 2'b01) $display("FAIL wr_idle_T2: en,ready=%b want 01", {d1_mem_en, d1_m1_ready}); else n_pass++;
    @(negedge clk);
    d1_m1_req = 1'b0;
    #1;
    n_chk++; if ({d1_mem_en, d1_mem_we, d1_mem_mask, d1_mem_addr} !== {2'b11, 4'h0, 32'h30})
      $display("FAIL wr_mask0: en=%0b we=%0b mask=%h addr=%h want 1 1 0 30", d1_mem_en, d1_mem_we, d1_mem_mask, d1_mem_addr); else n_pass++;
    step();
    n_chk++; if (d1_mem_en !== 1'b0) $display("FAIL wr_mask0_end: en=%0b want 0", d1_mem_en); else n_pass++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    m0_we = 1'b1; m0_addr = 32'h50; m0_mask = 4'h3; d1_m0_req = 1'b1;
    @(negedge clk);
    d1_m0_req = 1'b0;
    #1;
    n_chk++; if (d1_mem_en !== 1'b1) $display("FAIL rm_issue: en=%0b want 1", d1_mem_en); else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++; if ({d1_mem_en, d1_mem_we, d1_mem_addr, d1_mem_wdata, d1_mem_mask} !== 70'd0)
      $display("FAIL rm_async: en=%0b addr=%h wdata=%h want all 0", d1_mem_en, d1_mem_addr, d1_mem_wdata); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    m1_we = 1'b1; m1_addr = 32'h60; d1_m0_req = 1'b1; d1_m1_req = 1'b1;
    #1;
    n_chk++; if ({d1_m0_ready, d1_m1_ready} !== 2'b10) $display("FAIL rm_first_grant: got %b want 10", {d1_m0_ready, d1_m1_ready}); else n_pass++;
    @(negedge clk);
    d1_m0_req = 1'b0; d1_m1_req = 1'b0;
    step();
  endtask

  task automatic test_read;
    @(negedge clk);
    m1_we = 1'b0; m1_addr = 32'h20; d1_m1_req = 1'b1;
    #1;
    n_chk++; if ({d1_m0_ready, d1_m1_ready} !== 2'b01) $display("FAIL rd_ready: got %b want 01", {d1_m0_ready, d1_m1_ready}); else n_pass++;
    @(negedge clk);
    d1_m1_req = 1'b0;
    #1;
    n_chk++; if ({d1_mem_en, d1_mem_we, d1_mem_addr} !== {2'b10, 32'h20}) $display("FAIL rd_issue: en=%0b we=%0b addr=%h", d1_mem_en, d1_mem_we, d1_mem_addr); else n_pass++;
    step();
    n_chk++; if ({d1_mem_en, d1_m1_rvalid} !== 2'b00) $display("FAIL rd_T2: en,rvalid=%b want 00", {d1_mem_en, d1_m1_rvalid}); else n_pass++;
    step();
    n_chk++; if ({d1_m1_rvalid, d1_m0_rvalid} !== 2'b10 || d1_m1_rdata !== 32'h12345678)
      $display("FAIL rd_T3: rvalid1=%0b rvalid0=%0b rdata=%h want 1 0 12345678", d1_m1_rvalid, d1_m0_rvalid, d1_m1_rdata); else n_pass++;
    step();
    n_chk++; if (d1_m1_rvalid !== 1'b0 || d1_m1_rdata !== 32'h12345678) $display("FAIL rd_T4: rvalid=%0b rdata=%h", d1_m1_rvalid, d1_m1_rdata); else n_pass++;
  endtask

  task automatic test_round_robin;
    logic [31:0] e0, e1, ga;
    logic        got;
    int          w;
    e0 = 32'h0;
    e1 = 32'h12345678;
    @(negedge clk);
    m0_we = 1'b0; m1_we = 1'b0; m0_addr = 32'h100; m1_addr = 32'h200;
    d1_m0_req = 1'b1; d1_m1_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      w = 0;
      while (!(d1_m0_ready || d1_m1_ready) && w < 8) begin
        step();
        w++;
      end
      n_chk++; if (w >= 8) $display("FAIL rr_timeout: txn %0d no grant within 8 cycles", k); else n_pass++;
      got = d1_m1_ready;
      n_chk++; if ({d1_m0_ready, d1_m1_ready} !== {~k[0], k[0]}) $display("FAIL rr_grant: txn %0d got %b want %b", k, {d1_m0_ready, d1_m1_ready}, {~k[0], k[0]}); else n_pass++;
      ga = got ? m1_addr : m0_addr;
      @(negedge clk);
      if (got) m1_addr = m1_addr + 32'h4;
      else     m0_addr = m0_addr + 32'h4;
      step();
      step();
      if (got) begin
        e1 = mem_val(ga);
        n_chk++; if ({d1_m1_rvalid, d1_m0_rvalid} !== 2'b10 || d1_m1_rdata !== e1 || d1_m0_rdata !== e0)
          $display("FAIL rr_resp: txn %0d rv1=%0b rv0=%0b rd1=%h rd0=%h want 1 0 %h %h", k, d1_m1_rvalid, d1_m0_rvalid, d1_m1_rdata, d1_m0_rdata, e1, e0); else n_pass++;
      end else begin
        e0 = mem_val(ga);
        n_chk++; if ({d1_m0_rvalid, d1_m1_rvalid} !== 2'b10 || d1_m0_rdata !== e0 || d1_m1_rdata !== e1)
          $display("FAIL rr_resp: txn %0d rv0=%0b rv1=%0b rd0=%h rd1=%h want 1 0 %h %h", k, d1_m0_rvalid, d1_m1_rvalid, d1_m0_rdata, d1_m1_rdata, e0, e1); else n_pass++;
      end
      @(negedge clk);
      if (k == 5) begin
        d1_m0_req = 1'b0; d1_m1_req = 1'b0;
      end
    end
  endtask

  task automatic test_latency4;
    @(negedge clk);
    m0_we = 1'b0; m0_addr = 32'h40; d4_m0_req = 1'b1;
    #1;
    n_chk++; if (d4_m0_ready !== 1'b1) $display("FAIL l4_ready: got %0b want 1", d4_m0_ready); else n_pass++;
    @(negedge clk);
    d4_m0_req = 1'b0;
    #1;
    n_chk++; if ({d4_mem_en, d4_mem_we, d4_mem_addr} !== {2'b10, 32'h40}) $display("FAIL l4_issue: en=%0b addr=%h", d4_mem_en, d4_mem_addr); else n_pass++;
    for (int c = 2; c < 6; c++) begin
      step();
      n_chk++; if ({d4_m0_rvalid, d4_mem_en} !== 2'b00) $display("FAIL l4_wait: T+%0d rvalid,en=%b want 00", c, {d4_m0_rvalid, d4_mem_en}); else n_pass++;
    end
    step();
    n_chk++; if (d4_m0_rvalid !== 1'b1 || d4_m0_rdata !== 32'hCAFE0040) $display("FAIL l4_resp: rvalid=%0b rdata=%h want 1 cafe0040", d4_m0_rvalid, d4_m0_rdata); else n_pass++;
    step();
    n_chk++; if (d4_m0_rvalid !== 1'b0) $display("FAIL l4_after: rvalid=%0b want 0", d4_m0_rvalid); else n_pass++;
  endtask

  task automatic test_reset_in_wait;
    logic bad;
    @(negedge clk);
    m0_we = 1'b0; m0_addr = 32'h44; d4_m0_req = 1'b1;
    @(negedge clk);
    d4_m0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++; if (d4_m0_rdata !== 32'h0 || d4_mem_addr !== 32'h0 || d4_m0_rvalid !== 1'b0)
      $display("FAIL rw_async: rdata=%h addr=%h rvalid=%0b want 0", d4_m0_rdata, d4_mem_addr, d4_m0_rvalid); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (d4_m0_rvalid || d4_mem_en) bad = 1'b1;
    end
    n_chk++; if (bad !== 1'b0) $display("FAIL rw_no_resp: saw rvalid/mem_en after reset, got 1 want 0"); else n_pass++;
    n_chk++; if (d4_m0_rdata !== 32'h0) $display("FAIL rw_rdata: got %h want 0", d4_m0_rdata); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    m0_we = 1'b0; m1_we = 1'b0; m0_addr = '0; m1_addr = '0;
    m0_wdata = '0; m1_wdata = '0; m0_mask = '0; m1_mask = '0;
    d1_m0_req = 1'b0; d1_m1_req = 1'b0; d4_m0_req = 1'b0; d4_m1_req = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_reset_mid();
    test_read();
    test_round_robin();
    test_latency4();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
